// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage data cache: FSM encodings, geometry and address fields.
package arm_mem_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ_MISS  = 2'd1,
      WRITE_THRU = 2'd2
   } cache_state_t;

   localparam int SET_BITS_DEF = 6;
   localparam int IDX_LSB      = 2;   // word offset bits below the index
   localparam int SRAM_MSB     = 18;  // SRAM words span address[18:2]

   function automatic int tag_w(input int set_bits);
      return SRAM_MSB - IDX_LSB + 1 - set_bits;
   endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid/tag/data, asynchronous read by index, synchronous write.
module cache_way_array #(
   parameter int SET_BITS = 6,
   parameter int TAG_W    = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SET_BITS-1:0] idx,
   input  logic                we,
   input  logic [TAG_W-1:0]    wtag,
   input  logic [31:0]         wdata,
   output logic                valid,
   output logic [TAG_W-1:0]    tag,
   output logic [31:0]         data
);

   localparam int SETS = 1 << SET_BITS;

   logic [SETS-1:0]  valid_q;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [31:0]      data_q [SETS];

   // Only valid bits need reset; stale tag/data are masked by valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     valid_q      <= '0;
      else if (we) valid_q[idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[idx]  <= wtag;
         data_q[idx] <= wdata;
      end
   end

   assign valid = valid_q[idx];
   assign tag   = tag_q[idx];
   assign data  = data_q[idx];

endmodule

// File: rtl/mem_cache_controller.sv
// 2-way set-associative write-through, no-write-allocate data cache between MEM stage and SRAM.
// Optional CACHE_STATS_EN adds hit_count/miss_count load statistics outputs.
module mem_cache_controller
   import arm_mem_pkg::*;
#(
   parameter int SET_BITS = SET_BITS_DEF,
   parameter int TAG_W    = tag_w(SET_BITS)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        sram_w_en,
   output logic        sram_r_en,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   input  logic        sram_ready
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int SETS = 1 << SET_BITS;

   cache_state_t state, next_state;

   logic [SET_BITS-1:0] idx;
   logic [TAG_W-1:0]    tag;
   logic                v0, v1, hit0, hit1, hit, victim;
   logic [TAG_W-1:0]    t0, t1;
   logic [31:0]         d0, d1, wr_data;
   logic                we0, we1, lru_we, lru_val;
   logic [SETS-1:0]     lru;
   logic                unused_addr;

   assign idx          = address[IDX_LSB +: SET_BITS];
   assign tag          = address[SRAM_MSB -: TAG_W];
   assign unused_addr  = ^{address[31:SRAM_MSB+1], address[IDX_LSB-1:0]};
   assign sram_address = address;
   assign sram_wdata   = wdata;

   cache_way_array #(.SET_BITS(SET_BITS), .TAG_W(TAG_W)) u_way0 (
      .clk(clk), .rst(rst), .idx(idx), .we(we0), .wtag(tag), .wdata(wr_data),
      .valid(v0), .tag(t0), .data(d0));

   cache_way_array #(.SET_BITS(SET_BITS), .TAG_W(TAG_W)) u_way1 (
      .clk(clk), .rst(rst), .idx(idx), .we(we1), .wtag(tag), .wdata(wr_data),
      .valid(v1), .tag(t1), .data(d1));

   assign hit0   = v0 && (t0 == tag);
   assign hit1   = v1 && (t1 == tag);
   assign hit    = hit0 | hit1;
   // Fill an empty way first (way0 preferred), otherwise the LRU way.
   assign victim = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[idx]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         lru   <= '0;
      end else begin
         state <= next_state;
         if (lru_we) lru[idx] <= lru_val;
      end
   end

   always_comb begin
      next_state = state;
      ready      = 1'b0;
      sram_r_en  = 1'b0;
      sram_w_en  = 1'b0;
      rdata      = hit1 ? d1 : d0;
      wr_data    = wdata;
      we0        = 1'b0;
      we1        = 1'b0;
      lru_we     = 1'b0;
      lru_val    = hit0;
      case (state)
         IDLE: begin
            if (mem_w_en) begin
               sram_w_en  = 1'b1;
               next_state = WRITE_THRU;
               we0        = hit0;
               we1        = hit1;
               lru_we     = hit;
            end else if (mem_r_en) begin
               if (hit) begin
                  ready  = 1'b1;
                  lru_we = 1'b1;
               end else begin
                  sram_r_en  = 1'b1;
                  next_state = READ_MISS;
               end
            end else begin
               ready = 1'b1;
            end
         end
         READ_MISS: begin
            if (sram_ready) begin
               ready      = 1'b1;
               rdata      = sram_rdata;
               wr_data    = sram_rdata;
               we0        = !victim;
               we1        = victim;
               lru_we     = 1'b1;
               lru_val    = !victim;
               next_state = IDLE;
            end else begin
               sram_r_en = 1'b1;
            end
         end
         WRITE_THRU: begin
            if (sram_ready) begin
               ready      = 1'b1;
               next_state = IDLE;
            end else begin
               sram_w_en = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
      // Held request must not re-issue to SRAM while the SRAM controller is itself in reset.
      if (rst) begin
         sram_r_en = 1'b0;
         sram_w_en = 1'b0;
      end
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (state == IDLE && mem_r_en && !mem_w_en && hit) hit_count <= hit_count + 32'd1;
         if (state == READ_MISS && sram_ready)              miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_cache_controller.sv
// Directed table-driven bench for mem_cache_controller with a hand-timed SRAM responder.
module tb_mem_cache_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_en, mem_w_en;
   logic [31:0] address, wdata, rdata;
   logic        ready, sram_w_en, sram_r_en;
   logic [31:0] sram_address, sram_wdata, sram_rdata;
   logic        sram_ready;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] sram_mem [logic [31:0]];

   always #5 clk = ~clk;

   mem_cache_controller dut (
      .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
      .sram_w_en(sram_w_en), .sram_r_en(sram_r_en), .sram_address(sram_address),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        exp_hit;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (vec %0d) got %h expected %h", nm, id, got, exp);
      end
   endtask

   function automatic logic [31:0] sram_word(input logic [31:0] a);
      return sram_mem.exists(a) ? sram_mem[a] : (32'h1000_0000 | a);
   endfunction

   // Issues one request; hits complete in the issue cycle, others wait lat cycles for sram_ready.
   task automatic do_op(input int id, input vec_t v, input int lat);
      logic is_w;
      is_w = v.wr;
      @(negedge clk);
      sram_ready = 1'b0;
      mem_r_en = v.rd; mem_w_en = v.wr; address = v.addr; wdata = v.wd;
      #1;
      if (v.exp_hit) begin
         chk("hit_ready", id, {31'd0, ready}, 32'd1);
         chk("hit_no_sram_r", id, {31'd0, sram_r_en}, 32'd0);
         chk("hit_rdata", id, rdata, v.exp_rd);
      end else begin
         chk("issue_ready", id, {31'd0, ready}, 32'd0);
         chk("issue_en", id, {30'd0, sram_w_en, sram_r_en}, is_w ? 32'd2 : 32'd1);
         chk("sram_addr", id, sram_address, v.addr);
         if (is_w) chk("sram_wdata", id, sram_wdata, v.wd);
         for (int k = 0; k < lat; k++) begin
            @(negedge clk); #1;
            chk("hold_en", id, {29'd0, ready, sram_w_en, sram_r_en}, is_w ? 32'd2 : 32'd1);
         end
         @(negedge clk);
         sram_ready = 1'b1;
         sram_rdata = is_w ? 32'h0BAD_0BAD : sram_word(v.addr);
         if (is_w) sram_mem[v.addr] = v.wd;
         #1;
         chk("done_ready", id, {31'd0, ready}, 32'd1);
         chk("done_en_drop", id, {30'd0, sram_w_en, sram_r_en}, 32'd0);
         if (!is_w) chk("miss_rdata", id, rdata, v.exp_rd);
      end
   endtask

   initial begin
      rst = 1'b1; mem_r_en = 0; mem_w_en = 0; address = 0; wdata = 0;
      sram_rdata = 0; sram_ready = 0;

      //               rd wr addr       wdata          hit  rdata
      vecs[0]  = '{1, 0, 32'h100, 32'h0,          0, 32'h1000_0100};
      vecs[1]  = '{1, 0, 32'h100, 32'h0,          1, 32'h1000_0100};
      vecs[2]  = '{1, 0, 32'h200, 32'h0,          0, 32'h1000_0200};
      vecs[3]  = '{1, 0, 32'h200, 32'h0,          1, 32'h1000_0200};
      vecs[4]  = '{1, 0, 32'h300, 32'h0,          0, 32'h1000_0300};
      vecs[5]  = '{1, 0, 32'h200, 32'h0,          1, 32'h1000_0200};
      vecs[6]  = '{1, 0, 32'h100, 32'h0,          0, 32'h1000_0100};
      vecs[7]  = '{1, 0, 32'h300, 32'h0,          0, 32'h1000_0300};
      vecs[8]  = '{0, 1, 32'h100, 32'hDEADBEEF,   0, 32'h0};
      vecs[9]  = '{1, 0, 32'h100, 32'h0,          1, 32'hDEADBEEF};
      vecs[10] = '{0, 1, 32'h400, 32'h1234_5678,  0, 32'h0};
      vecs[11] = '{1, 0, 32'h400, 32'h0,          0, 32'h1234_5678};
      vecs[12] = '{1, 0, 32'h100, 32'h0,          1, 32'hDEADBEEF};
      vecs[13] = '{1, 0, 32'h104, 32'h0,          0, 32'h1000_0104};
      vecs[14] = '{1, 0, 32'h104, 32'h0,          1, 32'h1000_0104};
      vecs[15] = '{1, 1, 32'h104, 32'hCAFE_F00D,  0, 32'h0};
      vecs[16] = '{1, 0, 32'h104, 32'h0,          1, 32'hCAFE_F00D};

      #1;
      chk("rst_en", -1, {30'd0, sram_w_en, sram_r_en}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_ready", -1, {31'd0, ready}, 32'd1);
`ifdef CACHE_STATS_EN
      chk("rst_hits", -1, hit_count, 32'd0);
      chk("rst_misses", -1, miss_count, 32'd0);
`endif

      foreach (vecs[i]) do_op(i, vecs[i], 1 + (i % 3));

      @(negedge clk);
      sram_ready = 1'b0; mem_r_en = 0; mem_w_en = 0;
      #1;
      chk("idle_after", -2, {29'd0, ready, sram_w_en, sram_r_en}, 32'd4);
`ifdef CACHE_STATS_EN
      chk("hit_count", -2, hit_count, 32'd7);
      chk("miss_count", -2, miss_count, 32'd7);
`endif

      // Reset in the middle of a read miss: enables drop at once and cached lines are lost.
      @(negedge clk);
      mem_r_en = 1; address = 32'h108;
      #1;
      chk("rmiss_issue", -3, {31'd0, sram_r_en}, 32'd1);
      @(negedge clk); #1;
      chk("rmiss_hold", -3, {30'd0, ready, sram_r_en}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_en", -3, {30'd0, sram_w_en, sram_r_en}, 32'd0);
      @(negedge clk);
      chk("rst_mid_en2", -3, {30'd0, sram_w_en, sram_r_en}, 32'd0);
      rst = 1'b0; mem_r_en = 0;
      do_op(100, '{1, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF}, 2);
      do_op(101, '{1, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF}, 0);

      @(negedge clk);
      sram_ready = 1'b0; mem_r_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
